// File: rtl/regfile_pkg.sv
// Shared widths, limits and helpers for the parameterised register file.
`timescale 1ns/1ps
package regfile_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int ADDR_W_DEF = 5;
    localparam int NRD_DEF    = 2;
    localparam int NRD_MAX    = 4;
    localparam int WRCNT_W    = 16;

    // Hardwired-zero register sits at the top of the address space by default.
    function automatic int zero_reg_idx(input int addr_w);
        return (2 ** addr_w) - 1;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: storage mux, zero-register forcing, and optional
// write-to-read forwarding when REGFILE_BYPASS_EN is defined.
`timescale 1ns/1ps
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = zero_reg_idx(ADDR_W)
)(
    input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] i_rf,
    input  logic [ADDR_W-1:0]                  i_ra,
    input  logic                               i_rst,
    input  logic                               i_we0,
    input  logic [ADDR_W-1:0]                  i_rw0,
    input  logic [DATA_W-1:0]                  i_busw0,
    input  logic                               i_we1,
    input  logic [ADDR_W-1:0]                  i_rw1,
    input  logic [DATA_W-1:0]                  i_busw1,
    output logic [DATA_W-1:0]                  o_data
);

    localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] w_data;

    always_comb begin
        w_data = i_rf[i_ra];
`ifdef REGFILE_BYPASS_EN
        // Port 1 is checked first so it wins when both writers hit this address.
        if (!i_rst && (i_ra != ZADDR)) begin
            if (i_we1 && (i_rw1 == i_ra))
                w_data = i_busw1;
            else if (i_we0 && (i_rw0 == i_ra))
                w_data = i_busw0;
        end
`endif
        if (i_ra == ZADDR)
            w_data = '0;
    end

`ifndef REGFILE_BYPASS_EN
    logic w_unused;
    assign w_unused = &{1'b0, i_rst, i_we0, i_rw0, i_busw0, i_we1, i_rw1, i_busw1};
`endif

    assign o_data = w_data;

endmodule

// File: rtl/register_file_param.sv
// Multi-port register file: NRD combinational reads, two falling-edge write ports,
// saturating committed-write counter. Optional forwarding via REGFILE_BYPASS_EN.
`timescale 1ns/1ps
module register_file_param
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NRD      = NRD_DEF,
    parameter int ZERO_REG = zero_reg_idx(ADDR_W)
)(
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [NRD*ADDR_W-1:0]   RA,
    output logic [NRD*DATA_W-1:0]   BusR,
    input  logic [ADDR_W-1:0]       RW0,
    input  logic [ADDR_W-1:0]       RW1,
    input  logic [DATA_W-1:0]       BusW0,
    input  logic [DATA_W-1:0]       BusW1,
    input  logic                    RegWr0,
    input  logic                    RegWr1,
    output logic [WRCNT_W-1:0]      WrCount
);

    localparam int                DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_REG);

    logic [DEPTH-1:0][DATA_W-1:0] r_rf;
    logic [WRCNT_W-1:0]           r_wrcnt;

    logic                         w_wr0;
    logic                         w_wr1;
    logic                         w_coll;
    logic [1:0]                   w_inc;
    logic [WRCNT_W:0]             w_sum;

    // Writes aimed at the zero register never commit and never count.
    assign w_wr0  = RegWr0 && (RW0 != ZADDR);
    assign w_wr1  = RegWr1 && (RW1 != ZADDR);
    assign w_coll = w_wr0 && w_wr1 && (RW0 == RW1);

    always_comb begin
        w_inc = 2'(w_wr0) + 2'(w_wr1) - 2'(w_coll);
        w_sum = {1'b0, r_wrcnt} + (WRCNT_W+1)'(w_inc);
    end

    always_ff @(negedge Clk) begin
        if (Reset) begin
            r_rf    <= '0;
            r_wrcnt <= '0;
        end else begin
            if (w_wr0 && !w_coll)
                r_rf[RW0] <= BusW0;
            if (w_wr1)
                r_rf[RW1] <= BusW1;
            r_wrcnt <= w_sum[WRCNT_W] ? '1 : w_sum[WRCNT_W-1:0];
        end
    end

    assign WrCount = r_wrcnt;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        regfile_rd_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_rd (
            .i_rf    (r_rf),
            .i_ra    (RA[k*ADDR_W +: ADDR_W]),
            .i_rst   (Reset),
            .i_we0   (RegWr0),
            .i_rw0   (RW0),
            .i_busw0 (BusW0),
            .i_we1   (RegWr1),
            .i_rw1   (RW1),
            .i_busw1 (BusW1),
            .o_data  (BusR[k*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_register_file_param.sv
// Bench for register_file_param: directed scenarios plus randomized traffic
// against an array-based reference model. Honours REGFILE_BYPASS_EN.
`timescale 1ns/1ps
module tb_register_file_param;

    localparam int DW  = 64;
    localparam int AW  = 5;
    localparam int NR  = 2;
    localparam int ZR  = 31;

    logic              Clk = 1'b0;
    logic              Reset;
    logic [NR*AW-1:0]  RA;
    logic [NR*DW-1:0]  BusR;
    logic [AW-1:0]     RW0, RW1;
    logic [DW-1:0]     BusW0, BusW1;
    logic              RegWr0, RegWr1;
    logic [15:0]       WrCount;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] m_rf [32];
    int unsigned   m_cnt;

    register_file_param #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .ZERO_REG(ZR)) dut (
        .Clk(Clk), .Reset(Reset), .RA(RA), .BusR(BusR),
        .RW0(RW0), .RW1(RW1), .BusW0(BusW0), .BusW1(BusW1),
        .RegWr0(RegWr0), .RegWr1(RegWr1), .WrCount(WrCount)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Expected read value: zero register reads 0; otherwise the stored value,
    // unless forwarding applies before the edge (port 1 has precedence).
    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit pre);
        if (a == AW'(ZR)) return '0;
`ifdef REGFILE_BYPASS_EN
        if (pre && !Reset) begin
            if (RegWr1 && RW1 == a) return BusW1;
            if (RegWr0 && RW0 == a) return BusW0;
        end
`endif
        return m_rf[a];
    endfunction

    task automatic drive(input bit rst, input bit we0, input logic [AW-1:0] rw0, input logic [DW-1:0] d0,
                         input bit we1, input logic [AW-1:0] rw1, input logic [DW-1:0] d1,
                         input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        @(posedge Clk);
        #1;
        Reset = rst; RegWr0 = we0; RW0 = rw0; BusW0 = d0;
        RegWr1 = we1; RW1 = rw1; BusW1 = d1;
        RA = {ra1, ra0};
        #1;
    endtask

    // Waits for the committing edge and applies the architectural rules to the model.
    task automatic edge_commit();
        int n;
        @(negedge Clk);
        if (Reset) begin
            for (int i = 0; i < 32; i++) m_rf[i] = '0;
            m_cnt = 0;
        end else begin
            n = 0;
            if (RegWr0 && RW0 != AW'(ZR)) begin m_rf[RW0] = BusW0; n++; end
            if (RegWr1 && RW1 != AW'(ZR)) begin
                if (!(RegWr0 && RW0 == RW1)) n++;
                m_rf[RW1] = BusW1;
            end
            m_cnt = (m_cnt + n > 65535) ? 65535 : m_cnt + n;
        end
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, RA[AW-1:0], RA[2*AW-1:AW]);
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        edge_commit();
        for (int a = 0; a < 32; a += 2) begin
            drive(0, 0, 0, 0, 0, 0, 0, AW'(a), AW'(a+1));
            checks++;
            if (BusR !== '0) begin
                errors++;
                $display("FAIL reset_read a=%0d got=%h want=0", a, BusR);
            end
        end
        checks++;
        if (WrCount !== 16'd0) begin
            errors++;
            $display("FAIL reset_count got=%0d want=0", WrCount);
        end
    endtask

    task automatic test_seq_write();
        for (int k = 0; k < 31; k++) begin
            drive(0, 1, AW'(k), DW'(k), 0, 0, 0, 0, 0);
            edge_commit();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 5'd1, 5'd2);
        checks++;
        if (BusR[0 +: DW] !== 64'd1 || BusR[DW +: DW] !== 64'd2) begin
            errors++;
            $display("FAIL seq_read got=%h/%h want=1/2", BusR[0 +: DW], BusR[DW +: DW]);
        end
        checks++;
        if (WrCount !== 16'd31) begin
            errors++;
            $display("FAIL seq_count got=%0d want=31", WrCount);
        end
    endtask

    task automatic test_zero_reg();
        logic [15:0] c0;
        c0 = WrCount;
        drive(0, 1, 5'd31, 64'h12345678, 1, 5'd31, 64'hFFFF, 5'd31, 5'd31);
        checks++;
        if (BusR !== '0) begin
            errors++;
            $display("FAIL zero_pre got=%h want=0", BusR);
        end
        edge_commit();
        idle();
        checks++;
        if (BusR !== '0) begin
            errors++;
            $display("FAIL zero_read got=%h want=0", BusR);
        end
        checks++;
        if (WrCount !== c0 || WrCount !== 16'(m_cnt)) begin
            errors++;
            $display("FAIL zero_count got=%0d want=%0d", WrCount, m_cnt);
        end
    endtask

    task automatic test_collision();
        drive(0, 1, 5'd5, 64'hAAAA, 1, 5'd5, 64'hBBBB, 5'd5, 5'd6);
        edge_commit();
        idle();
        checks++;
        if (BusR[0 +: DW] !== 64'hBBBB) begin
            errors++;
            $display("FAIL collision_data got=%h want=bbbb", BusR[0 +: DW]);
        end
        checks++;
        if (WrCount !== 16'd32) begin
            errors++;
            $display("FAIL collision_count got=%0d want=32", WrCount);
        end
        // Distinct addresses on one edge both commit.
        drive(0, 1, 5'd8, 64'h8888, 1, 5'd9, 64'h9999, 5'd8, 5'd9);
        edge_commit();
        idle();
        checks++;
        if (BusR[0 +: DW] !== 64'h8888 || BusR[DW +: DW] !== 64'h9999 || WrCount !== 16'd34) begin
            errors++;
            $display("FAIL dual_write got=%h/%h cnt=%0d want=8888/9999 cnt=34",
                     BusR[0 +: DW], BusR[DW +: DW], WrCount);
        end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] want_pre;
`ifdef REGFILE_BYPASS_EN
        want_pre = 64'h55;
`else
        want_pre = 64'd3;
`endif
        drive(0, 1, 5'd3, 64'h55, 0, 0, 0, 5'd3, 5'd4);
        checks++;
        if (BusR[0 +: DW] !== want_pre) begin
            errors++;
            $display("FAIL bypass_pre got=%h want=%h", BusR[0 +: DW], want_pre);
        end
        edge_commit();
        checks++;
        if (BusR[0 +: DW] !== 64'h55) begin
            errors++;
            $display("FAIL bypass_post got=%h want=55", BusR[0 +: DW]);
        end
    endtask

    task automatic test_reset_priority();
        drive(1, 1, 5'd7, 64'hDEAD, 1, 5'd10, 64'hBEEF, 5'd7, 5'd10);
        checks++;
        if (BusR[0 +: DW] !== 64'd7 || BusR[DW +: DW] !== 64'd10) begin
            errors++;
            $display("FAIL reset_not_async got=%h/%h want=7/a", BusR[0 +: DW], BusR[DW +: DW]);
        end
        edge_commit();
        idle();
        checks++;
        if (BusR !== '0 || WrCount !== 16'd0) begin
            errors++;
            $display("FAIL reset_priority got=%h cnt=%0d want=0 cnt=0", BusR, WrCount);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] rw0, rw1, ra0, ra1;
        bit rst, we0, we1;
        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(0, 31) == 0);
            we0 = $urandom_range(0, 1);
            we1 = $urandom_range(0, 1);
            rw0 = AW'($urandom);
            rw1 = ($urandom_range(0, 3) == 0) ? rw0 : AW'($urandom);
            ra0 = ($urandom_range(0, 1) == 0) ? rw0 : AW'($urandom);
            ra1 = ($urandom_range(0, 1) == 0) ? rw1 : AW'($urandom);
            drive(rst, we0, rw0, {$urandom, $urandom}, we1, rw1, {$urandom, $urandom}, ra0, ra1);
            checks++;
            if (BusR[0 +: DW] !== exp_rd(ra0, 1) || BusR[DW +: DW] !== exp_rd(ra1, 1)) begin
                errors++;
                $display("FAIL rand_pre i=%0d got=%h/%h want=%h/%h", i,
                         BusR[0 +: DW], BusR[DW +: DW], exp_rd(ra0, 1), exp_rd(ra1, 1));
            end
            edge_commit();
            checks++;
            if (BusR[0 +: DW] !== exp_rd(ra0, 0) || BusR[DW +: DW] !== exp_rd(ra1, 0)
                || WrCount !== 16'(m_cnt)) begin
                errors++;
                $display("FAIL rand_post i=%0d got=%h/%h cnt=%0d want=%h/%h cnt=%0d", i,
                         BusR[0 +: DW], BusR[DW +: DW], WrCount,
                         exp_rd(ra0, 0), exp_rd(ra1, 0), m_cnt);
            end
        end
    endtask

    task automatic test_saturate();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        edge_commit();
        for (int i = 0; i < 32767; i++) begin
            drive(0, 1, 5'd1, 64'(i), 1, 5'd2, 64'(i + 1), 5'd1, 5'd2);
            edge_commit();
        end
        checks++;
        if (WrCount !== 16'hFFFE) begin
            errors++;
            $display("FAIL sat_near got=%h want=fffe", WrCount);
        end
        drive(0, 1, 5'd11, 64'h11, 1, 5'd12, 64'h12, 5'd11, 5'd12);
        edge_commit();
        checks++;
        if (WrCount !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_clamp got=%h want=ffff", WrCount);
        end
        drive(0, 1, 5'd13, 64'h13, 0, 0, 0, 5'd13, 5'd12);
        edge_commit();
        checks++;
        if (WrCount !== 16'hFFFF || BusR[0 +: DW] !== 64'h13 || BusR[DW +: DW] !== 64'h12) begin
            errors++;
            $display("FAIL sat_hold got=%h d=%h/%h want=ffff d=13/12",
                     WrCount, BusR[0 +: DW], BusR[DW +: DW]);
        end
    endtask

    initial begin
        Reset = 1'b1; RegWr0 = 1'b0; RegWr1 = 1'b0;
        RW0 = '0; RW1 = '0; BusW0 = '0; BusW1 = '0; RA = '0;
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        m_cnt = 0;
        test_reset();
        test_seq_write();
        test_zero_reg();
        test_collision();
        test_bypass();
        test_reset_priority();
        test_random();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
